// File: rtl/ctrl_74hc165.sv
`default_nettype none
//==============================================================================
// Module  : ctrl_74hc165
// Purpose : Free-running serial reader for a chain of 74HC165 PISO registers.
//           Generates PL/CP/CE for the chain, samples Q7 through a two-flop
//           synchroniser and presents each completed scan as a parallel word
//           (first shifted bit at the MSB) with a valid pulse and a changed
//           flag.
// Revision: 1.0 - initial release
//==============================================================================
module ctrl_74hc165 #(
   parameter int DATA_W = 16,   // bits in the chain, 8 per device, >= 2
   parameter int HALF   = 4,    // clk cycles per CP half-period / PL pulse, >= 2
   parameter int GAP    = 16    // idle clk cycles between scans, >= 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_q7,
   output logic              o_pl,
   output logic              o_cp,
   output logic              o_ce_n,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   output logic              o_changed
);

   // One timer serves both the half-period phases and the idle gap.
   localparam int c_tmr_max = (HALF > GAP) ? HALF : GAP;
   localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
   localparam int c_bit_w   = $clog2(DATA_W + 1);

   localparam logic [c_tmr_w-1:0] c_half_last = c_tmr_w'(HALF - 1);
   localparam logic [c_tmr_w-1:0] c_gap_last  = c_tmr_w'(GAP - 1);
   localparam logic [c_bit_w-1:0] c_bit_last  = c_bit_w'(DATA_W - 1);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_LOW  = 3'd2,
      ST_HIGH = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   state_t              state_q,   state_d;
   logic [c_tmr_w-1:0]  tmr_q,     tmr_d;
   logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   sr_q,      sr_d;
   logic [DATA_W-1:0]   data_q,    data_d;
   logic                pl_q,      pl_d;
   logic                cp_q,      cp_d;
   logic                ce_n_q,    ce_n_d;
   logic                valid_q,   valid_d;
   logic                changed_q, changed_d;

   // Q7 comes straight from the board and is asynchronous to clk.
   logic                q7_meta_q;
   logic                q7_sync_q;

   // Reset release is retimed here: the FSM may only leave IDLE once run_q[1]
   // is set, so a reset deassertion close to a clock edge cannot start a
   // scan in a partially-released state.
   logic [1:0]          run_q;

   logic                w_half_done;
   assign w_half_done = (tmr_q == c_half_last);

   // Next-state, datapath and next-output computation for the scan sequencer.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      bit_cnt_d = bit_cnt_q;
      sr_d      = sr_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      changed_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The gap is counted only while enabled, so a reassertion of
            // i_en always waits a full GAP before the next LOAD.
            if (!run_q[1] || !i_en) begin
               tmr_d = '0;
            end else if (tmr_q == c_gap_last) begin
               tmr_d     = '0;
               bit_cnt_d = '0;
               state_d   = ST_LOAD;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_LOAD: begin
            if (w_half_done) begin
               tmr_d   = '0;
               state_d = ST_LOW;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_LOW: begin
            if (w_half_done) begin
               // Sample at the end of LOW: Q7 has had 2*HALF cycles to settle
               // since the PL fall or CP rise that changed it.
               tmr_d     = '0;
               sr_d      = {sr_q[DATA_W-2:0], q7_sync_q};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == c_bit_last) begin
                  // Outputs are registered from the next state, so the word,
                  // valid and changed flags land together in the DONE cycle.
                  state_d   = ST_DONE;
                  data_d    = sr_d;
                  valid_d   = 1'b1;
                  changed_d = (sr_d != data_q);
               end else begin
                  state_d = ST_HIGH;
               end
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_HIGH: begin
            if (w_half_done) begin
               tmr_d   = '0;
               state_d = ST_LOW;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end

         ST_DONE: begin
            tmr_d   = '0;
            state_d = ST_IDLE;
         end

         default: begin
            tmr_d   = '0;
            state_d = ST_IDLE;
         end
      endcase

      // Pin levels follow the state being entered so they change on the same
      // edge as the state register.
      pl_d   = (state_d != ST_LOAD);
      cp_d   = (state_d == ST_HIGH);
      ce_n_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
   end

   // All state, synchroniser and output registers; reset parks the chain pins idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         tmr_q     <= '0;
         bit_cnt_q <= '0;
         sr_q      <= '0;
         data_q    <= '0;
         pl_q      <= 1'b1;
         cp_q      <= 1'b0;
         ce_n_q    <= 1'b1;
         valid_q   <= 1'b0;
         changed_q <= 1'b0;
         q7_meta_q <= 1'b0;
         q7_sync_q <= 1'b0;
         run_q     <= 2'b00;
      end else begin
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         bit_cnt_q <= bit_cnt_d;
         sr_q      <= sr_d;
         data_q    <= data_d;
         pl_q      <= pl_d;
         cp_q      <= cp_d;
         ce_n_q    <= ce_n_d;
         valid_q   <= valid_d;
         changed_q <= changed_d;
         q7_meta_q <= i_q7;
         q7_sync_q <= q7_meta_q;
         run_q     <= {run_q[0], 1'b1};
      end
   end

   assign o_pl      = pl_q;
   assign o_cp      = cp_q;
   assign o_ce_n    = ce_n_q;
   assign o_data    = data_q;
   assign o_valid   = valid_q;
   assign o_changed = changed_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_74hc165.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module  : tb_ctrl_74hc165
// Purpose : Self-checking bench for ctrl_74hc165 with a behavioural model of a
//           16-bit 74HC165 chain, a scoreboard keyed on PL pulses, a vector
//           table of consecutive scans and directed abort/enable sequences.
// Revision: 1.0 - initial release
//==============================================================================
module tb_ctrl_74hc165;

   localparam int DATA_W = 16;
   localparam int HALF   = 2;
   localparam int GAP    = 4;
   localparam int PERIOD = 2 * HALF * DATA_W + 1 + GAP;   // 69
   localparam int BUDGET = 4 * PERIOD;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic              i_en  = 1'b0;
   logic              i_q7;
   logic              o_pl, o_cp, o_ce_n, o_valid, o_changed;
   logic [DATA_W-1:0] o_data;

   int checks = 0;
   int errors = 0;

   ctrl_74hc165 #(.DATA_W(DATA_W), .HALF(HALF), .GAP(GAP)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_en      (i_en),
      .i_q7      (i_q7),
      .o_pl      (o_pl),
      .o_cp      (o_cp),
      .o_ce_n    (o_ce_n),
      .o_data    (o_data),
      .o_valid   (o_valid),
      .o_changed (o_changed)
   );

   always #5 clk = ~clk;

   // Behavioural 2x74HC165 chain: transparent load while PL is low, shift on
   // a CP rise while PL is high and CE is low; Q7 is the chain MSB.
   logic [DATA_W-1:0] par_in = '0;
   logic [DATA_W-1:0] chain  = '0;
   logic              cp_seen = 1'b0;
   always @(o_pl or o_cp or o_ce_n or par_in) begin
      if (!o_pl)
         chain = par_in;
      else if (o_cp && !cp_seen && !o_ce_n)
         chain = chain << 1;
      cp_seen = o_cp;
   end
   assign i_q7 = chain[DATA_W-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Parallel inputs scrambled every cycle while PL is high, when enabled.
   bit toggle = 1'b0;
   always @(negedge clk) begin
      if (toggle && o_pl)
         par_in = DATA_W'($urandom);
   end

   // Monitor and scoreboard: the word expected from each scan is whatever
   // sat on the parallel inputs during its PL-low window.
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] latched    = '0;
   logic [DATA_W-1:0] last_model = '0;
   logic [DATA_W-1:0] exp_word;
   bit pl_prev = 1'b1, cp_prev = 1'b0, valid_prev = 1'b0, in_scan = 1'b0;
   int pl_falls = 0, pl_low = 0, cp_rises = 0, cp_falls = 0, ce_bad = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         last_model = '0;
         in_scan    = 1'b0;
         pl_prev    = 1'b1;
         cp_prev    = 1'b0;
         valid_prev = 1'b0;
         pl_falls   = 0;
         cp_rises   = 0;
         cp_falls   = 0;
      end else begin
         if (!o_pl) begin
            latched = par_in;
            if (pl_prev) begin
               pl_falls++;
               pl_low   = 0;
               in_scan  = 1'b1;
               ce_bad   = 0;
               cp_rises = 0;
               cp_falls = 0;
            end
            pl_low++;
         end
         if (o_pl && !pl_prev)
            exp_q.push_back(latched);
         if (o_cp && !cp_prev)
            cp_rises++;
         if (!o_cp && cp_prev)
            cp_falls++;
         if (in_scan && !o_valid && o_ce_n)
            ce_bad++;
         if (o_valid) begin
            check("valid_single_cycle", 32'(valid_prev), 32'd0);
            check("pl_pulses_per_scan", pl_falls, 1);
            check("pl_low_width", pl_low, HALF);
            check("cp_rises_per_scan", cp_rises, DATA_W - 1);
            check("ce_n_low_window", ce_bad, 0);
            if (exp_q.size() == 0) begin
               check("sb_word_available", 32'd0, 32'd1);
            end else begin
               exp_word = exp_q.pop_front();
               check("sb_data", 32'(o_data), 32'(exp_word));
               check("sb_changed", 32'(o_changed), 32'(exp_word != last_model));
               last_model = exp_word;
            end
            in_scan  = 1'b0;
            pl_falls = 0;
         end
         pl_prev    = o_pl;
         cp_prev    = o_cp;
         valid_prev = o_valid;
      end
   end

   // Waits for the next o_valid, counting negedges; gives up after BUDGET.
   task automatic wait_valid(output int n, output bit got);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_valid && n < BUDGET);
      got = o_valid;
   endtask

   typedef struct {
      logic [DATA_W-1:0] pat;
      logic [DATA_W-1:0] exp_data;
      logic              exp_changed;
   } vec_t;

   localparam int NVEC = 8;
   vec_t tbl [NVEC];

   int n, bad;
   bit got;

   initial begin
      tbl[0] = '{16'hA5C3, 16'hA5C3, 1'b1};
      tbl[1] = '{16'hA5C3, 16'hA5C3, 1'b0};
      tbl[2] = '{16'h0001, 16'h0001, 1'b1};
      tbl[3] = '{16'h8000, 16'h8000, 1'b1};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1};
      tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b0};
      tbl[6] = '{16'h0000, 16'h0000, 1'b1};
      tbl[7] = '{16'h5A3C, 16'h5A3C, 1'b1};

      // Reset state
      rst_n  = 1'b0;
      i_en   = 1'b1;
      par_in = tbl[0].pat;
      repeat (3) @(negedge clk);
      check("rst_pl", 32'(o_pl), 32'd1);
      check("rst_cp", 32'(o_cp), 32'd0);
      check("rst_ce_n", 32'(o_ce_n), 32'd1);
      check("rst_data", 32'(o_data), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_changed", 32'(o_changed), 32'd0);
      #1 rst_n = 1'b1;

      // Vector table: consecutive scans with i_en held high
      for (int i = 0; i < NVEC; i++) begin
         wait_valid(n, got);
         check($sformatf("tbl%0d_got_valid", i), 32'(got), 32'd1);
         check($sformatf("tbl%0d_data", i), 32'(o_data), 32'(tbl[i].exp_data));
         check($sformatf("tbl%0d_changed", i), 32'(o_changed), 32'(tbl[i].exp_changed));
         if (i > 0)
            check($sformatf("tbl%0d_period", i), n + 1, PERIOD);
         if (i + 1 < NVEC)
            par_in = tbl[i + 1].pat;
         @(negedge clk);
         check($sformatf("tbl%0d_valid_drop", i), 32'(o_valid), 32'd0);
      end

      // Random words, stable during each scan
      for (int k = 0; k < 6; k++) begin
         par_in = DATA_W'($urandom);
         wait_valid(n, got);
         check("rand_got_valid", 32'(got), 32'd1);
      end

      // Inputs scrambled every cycle while PL is high
      toggle = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_valid(n, got);
         check("toggle_got_valid", 32'(got), 32'd1);
      end
      toggle = 1'b0;

      // Reset during the 8th LOW phase of a scan
      par_in = 16'h3C96;
      n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (!(in_scan && !o_pl == 1'b0 && cp_falls == 7 && !o_cp) && n < BUDGET);
      check("abort_reached_low8", 32'(n < BUDGET), 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_pl", 32'(o_pl), 32'd1);
      check("abort_cp", 32'(o_cp), 32'd0);
      check("abort_ce_n", 32'(o_ce_n), 32'd1);
      check("abort_data", 32'(o_data), 32'd0);
      check("abort_valid", 32'(o_valid), 32'd0);
      check("abort_changed", 32'(o_changed), 32'd0);
      repeat (3) @(negedge clk);
      par_in = 16'h6E19;
      #1 rst_n = 1'b1;
      wait_valid(n, got);
      check("abort_next_valid", 32'(got), 32'd1);
      check("abort_no_early_valid", 32'(n >= 2 * HALF * DATA_W + GAP), 32'd1);
      check("abort_next_data", 32'(o_data), 32'h6E19);
      check("abort_next_changed", 32'(o_changed), 32'd1);

      // i_en dropped during a HIGH phase
      par_in = 16'hC0DE;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!o_cp && n < BUDGET);
      check("en_drop_reached_high", 32'(o_cp), 32'd1);
      i_en = 1'b0;
      wait_valid(n, got);
      check("en_drop_valid", 32'(got), 32'd1);
      check("en_drop_data", 32'(o_data), 32'hC0DE);
      bad = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (o_pl !== 1'b1 || o_cp !== 1'b0 || o_valid !== 1'b0)
            bad++;
      end
      check("en_drop_idle_pins", bad, 0);
      par_in = 16'h1234;
      i_en   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (o_pl && n < BUDGET);
      check("en_reassert_load_delay", n, GAP);
      wait_valid(n, got);
      check("en_reassert_valid", 32'(got), 32'd1);
      check("en_reassert_data", 32'(o_data), 32'h1234);
      check("en_reassert_changed", 32'(o_changed), 32'd1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
